// File: rtl/uart_fifo_tx_if.sv
// CPU/UART-TX handshake bundle for the transmit FIFO.
// The bench drives through the master side; uart_fifo_tx sits on the slave side.
interface uart_fifo_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] w_data;
    logic              wr;
    logic              tx_done;
    logic [DATA_W-1:0] d_in;
    logic              tx_full;
    logic              tx_start;

    modport master (
        output w_data, wr, tx_done,
        input  d_in, tx_full, tx_start
    );

    modport slave (
        input  w_data, wr, tx_done,
        output d_in, tx_full, tx_start
    );
endinterface

// File: rtl/uart_fifo_tx.sv
// Transmit-side FIFO between the CPU and the UART transmitter.
// One FSM serialises CPU pushes and TX pops, so both never happen together.
//
//   state          | meaning
//   ---------------+-------------------------------------------------
//   IDLE           | wait for a CPU write (has priority) or TX ready
//   ENVIO_A_TX     | d_in loaded, tx_start strobe, entry released
//   ESPERO_A_TX    | wait for tx_done to drop
//   RECIBO_DE_CPU  | store w_data unless the FIFO is full
//   ESPERO_A_CPU   | wait for wr to drop
module uart_fifo_tx #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_fifo_tx_if.slave  bus
);
    localparam logic [3:0] IDLE          = 4'd0;
    localparam logic [3:0] ENVIO_A_TX    = 4'd1;
    localparam logic [3:0] ESPERO_A_TX   = 4'd2;
    localparam logic [3:0] RECIBO_DE_CPU = 4'd3;
    localparam logic [3:0] ESPERO_A_CPU  = 4'd4;

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [3:0]        current_state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] d_in_q;
    logic [DATA_W-1:0] stack [DEPTH];
    logic              stack_empty;
    logic              push;

    assign stack_empty  = (count == '0);
    assign bus.tx_full  = (count == FULL_CNT);
    assign bus.tx_start = (current_state == ENVIO_A_TX);
    assign bus.d_in     = d_in_q;
    // A write attempt while full is dropped without any indication.
    assign push         = (current_state == RECIBO_DE_CPU) && !bus.tx_full;

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[wr_ptr] <= bus.w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_state <= IDLE;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            d_in_q        <= '0;
        end else begin
            case (current_state)
                IDLE: begin
                    if (bus.wr) begin
                        current_state <= RECIBO_DE_CPU;
                    end else if (bus.tx_done && !stack_empty) begin
                        current_state <= ENVIO_A_TX;
                        d_in_q        <= stack[rd_ptr];
                        rd_ptr        <= rd_ptr + 1'b1;
                    end
                end
                RECIBO_DE_CPU: begin
                    if (push) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        count  <= count + 1'b1;
                    end
                    current_state <= ESPERO_A_CPU;
                end
                ESPERO_A_CPU: begin
                    if (!bus.wr) begin
                        current_state <= IDLE;
                    end
                end
                ENVIO_A_TX: begin
                    count         <= count - 1'b1;
                    current_state <= ESPERO_A_TX;
                end
                ESPERO_A_TX: begin
                    if (!bus.tx_done) begin
                        current_state <= IDLE;
                    end
                end
                default: current_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_fifo_tx.sv
// Self-checking bench for uart_fifo_tx against a queue-based reference model.
module tb_uart_fifo_tx;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [7:0] model_q [$];
    logic [7:0] last_d;

    uart_fifo_tx_if #(.DATA_W(8)) bus ();

    uart_fifo_tx #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One CPU write: wr held for `hold` cycles, then released for one cycle.
    task automatic do_write(input logic [7:0] b, input int hold);
        int starts;
        starts = 0;
        bus.w_data = b;
        bus.wr     = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (bus.tx_start) starts++;
        end
        if (model_q.size() < 16) model_q.push_back(b);
        chk("wr_state", 32'(dut.current_state), 32'd4);
        chk("wr_count", 32'(dut.count), 32'(model_q.size()));
        chk("wr_full", 32'(bus.tx_full), 32'(model_q.size() == 16));
        bus.wr = 1'b0;
        tick();
        if (bus.tx_start) starts++;
        chk("wr_idle", 32'(dut.current_state), 32'd0);
        chk("wr_nostart", 32'(starts), 32'd0);
    endtask

    // One TX-ready period: tx_done held for `hold` cycles (hold >= 3).
    task automatic do_send(input int hold);
        int         starts;
        logic [7:0] seen;
        int         exp_starts;
        starts = 0;
        seen   = '0;
        exp_starts = (model_q.size() != 0) ? 1 : 0;
        bus.tx_done = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (bus.tx_start) begin
                starts++;
                seen = bus.d_in;
            end
        end
        chk("tx_pulses", 32'(starts), 32'(exp_starts));
        if (exp_starts == 1) begin
            last_d = model_q.pop_front();
            chk("tx_data", 32'(seen), 32'(last_d));
        end
        chk("tx_state", 32'(dut.current_state), (exp_starts == 1) ? 32'd2 : 32'd0);
        chk("tx_full", 32'(bus.tx_full), 32'(model_q.size() == 16));
        bus.tx_done = 1'b0;
        tick();
        chk("tx_idle", 32'(dut.current_state), 32'd0);
        chk("tx_start_low", 32'(bus.tx_start), 32'd0);
        chk("tx_dhold", 32'(bus.d_in), 32'(last_d));
        chk("tx_count", 32'(dut.count), 32'(model_q.size()));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        last_d  = '0;
        bus.w_data  = '0;
        bus.wr      = 1'b0;
        bus.tx_done = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("rst_d_in", 32'(bus.d_in), 32'd0);
        chk("rst_start", 32'(bus.tx_start), 32'd0);
        chk("rst_full", 32'(bus.tx_full), 32'd0);
        chk("rst_state", 32'(dut.current_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Empty FIFO: tx_done alone produces nothing.
        do_send(5);

        // Basic write then send of 50.
        do_write(8'd50, 5);
        do_send(5);
        chk("empty_after", 32'(dut.count), 32'd0);

        // Fill to 16, overflow byte dropped, drain in order.
        for (int i = 1; i <= 16; i++) do_write(8'(i), 2 + int'($urandom_range(0, 3)));
        chk("full_set", 32'(bus.tx_full), 32'd1);
        do_write(8'd99, 3);
        for (int i = 0; i < 16; i++) do_send(3 + int'($urandom_range(0, 3)));
        chk("drained", 32'(dut.count), 32'd0);

        // Pointer wrap-around with random bytes and random operation mix.
        for (int i = 0; i < 20; i++) begin
            do_write(8'($urandom), 2 + int'($urandom_range(0, 2)));
            if ($urandom_range(0, 2) != 0) do_send(3 + int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) do_write(8'($urandom), 2 + int'($urandom_range(0, 2)));
            else do_send(3 + int'($urandom_range(0, 2)));
        end

        // Write has priority over tx_done in IDLE.
        if (model_q.size() == 0) do_write(8'hA5, 2);
        bus.w_data  = 8'h3C;
        bus.wr      = 1'b1;
        bus.tx_done = 1'b1;
        tick();
        chk("prio_state", 32'(dut.current_state), 32'd3);
        chk("prio_nostart", 32'(bus.tx_start), 32'd0);
        tick();
        if (model_q.size() < 16) model_q.push_back(8'h3C);
        bus.wr      = 1'b0;
        bus.tx_done = 1'b0;
        tick();
        chk("prio_idle", 32'(dut.current_state), 32'd0);
        chk("prio_count", 32'(dut.count), 32'(model_q.size()));

        // Asynchronous reset while waiting in ESPERO_A_TX.
        do_write(8'h77, 2);
        bus.tx_done = 1'b1;
        tick();
        tick();
        tick();
        chk("pre_rst_state", 32'(dut.current_state), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(dut.current_state), 32'd0);
        chk("arst_count", 32'(dut.count), 32'd0);
        chk("arst_d_in", 32'(bus.d_in), 32'd0);
        chk("arst_start", 32'(bus.tx_start), 32'd0);
        bus.tx_done = 1'b0;
        model_q.delete();
        last_d = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_send(4);
        do_write(8'h12, 2);
        do_send(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
